divisor_restauracion: RTL

//   Sequential unsigned restoring divider; the inverse operation of the team's

---
 rtl/divisor_restauracion.sv | 132 +++++++++++++
 1 files changed

// File: rtl/divisor_restauracion.sv
// divisor_restauracion: sequential unsigned restoring divider.
// Uses the same A/Q/M register organisation as the shift-add multiplier.
// Each quotient bit takes three cycles: shift, trial subtract, then check/restore.
// A division by zero is flagged and completes one cycle after start.
//
// Ports
//   clk        clock; all state updates happen on the rising edge
//   reset      synchronous, active-high reset
//   inicio     start request; sampled only in IDLE or FIN
//   dividendo  dividend, captured into Q on start
//   divisor    divisor, captured into M on start
//   cociente   quotient (register Q)
//   resto      remainder (A[N-1:0])
//   Fin        high while the result is valid
//   div_cero   high together with Fin when the captured divisor was zero
module divisor_restauracion #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inicio,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] cociente,
    output logic [N-1:0] resto,
    output logic         Fin,
    output logic         div_cero
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        StIdle,
        StDesplaza,
        StResta,
        StComprueba,
        StFin
    } state_e;

    state_e          state_q, state_d;
    logic [N:0]      a_q, a_d;      // A[N] is the sign of the partial remainder
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    m_q, m_d;
    logic [CW-1:0]   cont_q, cont_d;
    logic            fin_q, fin_d;
    logic            dz_q, dz_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cont_q  <= '0;
            fin_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cont_q  <= cont_d;
            fin_q   <= fin_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cont_d  = cont_q;
        fin_d   = fin_q;
        dz_d    = dz_q;

        case (state_q)
            StIdle, StFin: begin
                if (inicio) begin
                    m_d    = divisor;
                    cont_d = CW'(N);
                    if (divisor == '0) begin
                        // No iterations: report all-ones quotient and the
                        // dividend as remainder straight away.
                        a_d     = {1'b0, dividendo};
                        q_d     = '1;
                        fin_d   = 1'b1;
                        dz_d    = 1'b1;
                        state_d = StFin;
                    end else begin
                        a_d     = '0;
                        q_d     = dividendo;
                        fin_d   = 1'b0;
                        dz_d    = 1'b0;
                        state_d = StDesplaza;
                    end
                end
            end
            StDesplaza: begin
                {a_d, q_d} = {a_q[N-1:0], q_q, 1'b0};
                state_d    = StResta;
            end
            StResta: begin
                a_d     = a_q - {1'b0, m_q};
                state_d = StComprueba;
            end
            StComprueba: begin
                if (a_q[N]) begin
                    // Trial subtraction went negative: undo it, quotient bit 0.
                    a_d    = a_q + {1'b0, m_q};
                    q_d[0] = 1'b0;
                end else begin
                    q_d[0] = 1'b1;
                end
                cont_d = cont_q - CW'(1);
                if (cont_q == CW'(1)) begin
                    fin_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    state_d = StDesplaza;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cociente = q_q;
    assign resto    = a_q[N-1:0];
    assign Fin      = fin_q;
    assign div_cero = dz_q;

endmodule
